// File: rtl/load_store_unit.sv
// MEM-stage RV32I load/store sequencer driving the data port of the shared memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of aligning).
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module load_store_unit #(
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [`DATA_BITS-3:0] mem_addr,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_bsv,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT_LO,
        S_RD_WAIT_HI,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [`DATA_BITS-3:0] mem_addr_q, mem_addr_d;
    logic                  mem_ren_q, mem_ren_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_bsv_q, mem_bsv_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic                  req_illegal;
    logic                  req_trap;
    logic [1:0]            req_off;
    logic [31:0]           st_wdata;
    logic [3:0]            st_bsv;
    logic [31:0]           rd_shift;
    logic [31:0]           ld_data;
    logic                  timer_expired;
    logic                  unused_addr_bits;

    // Address bits above the memory size never reach the port.
    assign unused_addr_bits = ^req_addr[31:`DATA_BITS];

    assign busy      = req_valid & (state_q != S_DONE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_bsv   = mem_bsv_q;

    assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

    // Request decode: legality, aligned byte offset and store lane placement.
    always_comb begin
        if (req_we) begin
            req_illegal = (req_funct3 >= 3'b011);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end

        case (req_funct3[1:0])
            2'b01:   req_off = {req_addr[1], 1'b0};
            2'b10:   req_off = 2'b00;
            default: req_off = req_addr[1:0];
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        req_trap = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_trap = 1'b0;
`endif

        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_bsv   = 4'b0001 << req_off;
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_bsv   = req_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = req_wdata;
                st_bsv   = 4'b1111;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend.
    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_data = {24'h0, rd_shift[7:0]};
            3'b101:  ld_data = {16'h0, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_ren_d   = 1'b0;
        mem_wen_d   = 1'b0;
        mem_wdata_d = mem_wdata_q;
        mem_bsv_d   = mem_bsv_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        timer_d     = timer_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d    = req_funct3;
                    off_d       = req_off;
                    timer_d     = '0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (req_illegal || req_trap) begin
                        state_d   = S_DONE;
                        rsp_err_d = 1'b1;
                    end else begin
                        mem_addr_d = req_addr[`DATA_BITS-1:2];
                        if (req_we) begin
                            state_d     = S_WR;
                            mem_wen_d   = 1'b1;
                            mem_wdata_d = st_wdata;
                            mem_bsv_d   = st_bsv;
                        end else begin
                            // Read enable is a single-cycle pulse; holding it restarts the read.
                            state_d     = S_RD_ISSUE;
                            mem_ren_d   = 1'b1;
                            mem_wdata_d = '0;
                            mem_bsv_d   = '0;
                        end
                    end
                end
            end
            S_WR: begin
                state_d = S_DONE;
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT_LO;
            end
            S_RD_WAIT_LO: begin
                timer_d = timer_q + 1'b1;
                if (timer_expired) begin
                    state_d     = S_DONE;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (!mem_ready) begin
                    state_d = S_RD_WAIT_HI;
                end
            end
            S_RD_WAIT_HI: begin
                timer_d = timer_q + 1'b1;
                if (mem_ready) begin
                    state_d     = S_DONE;
                    rsp_rdata_d = ld_data;
                end else if (timer_expired) begin
                    state_d     = S_DONE;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_bsv_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bsv_q   <= mem_bsv_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            timer_q     <= timer_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory model with variable read latency
// plus a byte-array reference of memory contents for expected load/store results.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module tb_load_store_unit;
    localparam int AW        = `DATA_BITS - 2;
    localparam int TIMEOUT   = 32;
    localparam int MEM_WORDS = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          busy;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_ren;
    logic          mem_wen;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_bsv;
    logic [31:0]   mem_rdata;
    logic          mem_ready;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_bsv(mem_bsv),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0]   words [0:MEM_WORDS-1];
    logic [AW-1:0] rd_idx;
    int            rd_cnt;
    int            mem_lat = 7;
    bit            stub_hi = 1'b0;
    bit            init_req = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            rd_cnt    <= 0;
            rd_idx    <= '0;
        end else begin
            if (init_req)
                for (int i = 0; i < MEM_WORDS; i++) words[i] <= init_word(i);
            if (mem_wen && int'(mem_addr) < MEM_WORDS)
                for (int k = 0; k < 4; k++)
                    if (mem_bsv[k]) words[mem_addr[7:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
            if (stub_hi) begin
                mem_ready <= 1'b1;
            end else if (mem_ren) begin
                mem_ready <= 1'b0;
                rd_cnt    <= mem_lat - 1;
                rd_idx    <= mem_addr;
            end else if (rd_cnt != 0) begin
                rd_cnt <= rd_cnt - 1;
                if (rd_cnt == 1) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= (int'(rd_idx) < MEM_WORDS) ? words[rd_idx[7:0]] : 32'h0;
                end
            end
        end
    end

    // ---------------- reference and scoreboard ----------------
    logic [7:0]  ref_b [0:4*MEM_WORDS-1];
    logic [31:0] exp_q [$];
    logic [2:0]  ld_tab [0:4] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    int errors = 0;
    int checks = 0;

    logic [31:0]   got_rdata;
    logic          got_err;
    int            got_lat;
    int            got_ren_n;
    int            got_wen_n;
    logic [3:0]    got_bsv;
    logic [31:0]   got_wdata;
    logic [AW-1:0] got_maddr;
    bit            got_timed_out;
    int            busy_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return (a < 32'(4 * MEM_WORDS)) ? ref_b[a[9:0]] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int size, input bit sgn);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < size; i++) v = v | ({24'h0, ref_byte(a + 32'(i))} << (8 * i));
        if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data);
        int  cyc;
        bit  done;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = data;
        cyc = 1; done = 0;
        got_ren_n = 0; got_wen_n = 0; got_bsv = '0; got_wdata = '0; got_maddr = '0;
        got_rdata = '0; got_err = 1'b0; got_lat = 0; busy_bad = 0;
        while (!done && cyc <= 100) begin
            @(negedge clk);
            if (mem_ren) begin got_ren_n++; got_maddr = mem_addr; end
            if (mem_wen) begin
                got_wen_n++; got_bsv = mem_bsv; got_wdata = mem_wdata; got_maddr = mem_addr;
            end
            if (rsp_valid) begin
                done = 1; got_rdata = rsp_rdata; got_err = rsp_err; got_lat = cyc;
                if (busy) busy_bad++;
            end else begin
                if (!busy) busy_bad++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        got_timed_out = !done;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data);
        bit          legal, sgn, exp_err;
        int          size;
        logic [31:0] a, exp_rdata, exp_wdata;
        logic [3:0]  exp_bsv;
        legal   = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        size    = 1 << f3[1:0];
        sgn     = !f3[2];
        a       = addr & ~(32'(size) - 32'd1);
        exp_err = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
        if (legal && a != addr) exp_err = 1'b1;
`endif
        exp_rdata = '0;
        if (!exp_err && !we) exp_rdata = ref_load(a, size, sgn);
        exp_q.push_back(exp_rdata);
        do_access(we, f3, addr, data);
        check("no_hang", 32'(got_timed_out), 0);
        check("busy", busy_bad, 0);
        check("rsp_err", 32'(got_err), 32'(exp_err));
        check("rsp_rdata", got_rdata, exp_q.pop_front());
        check("ren_cycles", got_ren_n, (!exp_err && !we) ? 1 : 0);
        check("wen_cycles", got_wen_n, (!exp_err && we) ? 1 : 0);
        if (exp_err) begin
            check("err_latency", got_lat, 2);
        end else if (we) begin
            exp_bsv = '0;
            for (int i = 0; i < size; i++) exp_bsv[(a + 32'(i)) % 4] = 1'b1;
            if (size == 1)      exp_wdata = {24'h0, data[7:0]} * 32'h0101_0101;
            else if (size == 2) exp_wdata = {16'h0, data[15:0]} * 32'h0001_0001;
            else                exp_wdata = data;
            check("st_bsv", 32'(got_bsv), 32'(exp_bsv));
            check("st_wdata", got_wdata, exp_wdata);
            check("st_addr", 32'(got_maddr), 32'(a[AW+1:2]));
            check("st_latency", got_lat, 3);
            for (int i = 0; i < size; i++)
                if (a + 32'(i) < 32'(4 * MEM_WORDS)) ref_b[(a + 32'(i)) % (4 * MEM_WORDS)] = data[8*i +: 8];
        end else begin
            check("ld_addr", 32'(got_maddr), 32'(a[AW+1:2]));
            check("ld_latency", got_lat, 3 + mem_lat);
        end
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 0);
    endtask

    task automatic count_rsp(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  seen;
        bit  found;
        for (int i = 0; i < MEM_WORDS; i++)
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = init_word(i) >> (8 * k);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_mem_ren", 32'(mem_ren), 0);
        check("rst_mem_wen", 32'(mem_wen), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_bsv", 32'(mem_bsv), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        @(posedge clk); #1; init_req = 1'b1;
        @(posedge clk); #1; init_req = 1'b0;

        // Directed cases
        mem_lat = 7;
        run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        check("t1_addr", 32'(got_maddr), 32'h40);
        check("t1_bsv", 32'(got_bsv), 32'hF);
        check("t1_lat", got_lat, 3);
        run_txn(1'b1, 3'b000, 32'h103, 32'h0000_00A5);
        check("t2_bsv", 32'(got_bsv), 32'h8);
        check("t2_wdata", got_wdata, 32'hA5A5_A5A5);
        run_txn(1'b0, 3'b000, 32'h103, 32'h0);
        check("t2_lb", got_rdata, 32'hFFFF_FFA5);
        run_txn(1'b0, 3'b100, 32'h103, 32'h0);
        check("t2_lbu", got_rdata, 32'h0000_00A5);
        run_txn(1'b1, 3'b010, 32'h100, 32'h8001_7FFF);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0);
        check("t3_lh", got_rdata, 32'hFFFF_8001);
        check("t3_lh_ren", got_ren_n, 1);
        run_txn(1'b0, 3'b101, 32'h100, 32'h0);
        check("t3_lhu", got_rdata, 32'h0000_7FFF);
        check("t3_lat", got_lat, 10);
        run_txn(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("t6_err", 32'(got_err), 1);
        check("t6_ren", got_ren_n, 0);
        check("t6_lat", got_lat, 2);
`else
        check("t6_err", 32'(got_err), 0);
        check("t6_addr", 32'(got_maddr), 32'h40);
        check("t6_word", got_rdata, 32'h8001_7FFF);
`endif

        // Timeout with a memory that never drops ready
        stub_hi = 1'b1;
        do_access(1'b0, 3'b010, 32'h0, 32'h0);
        check("to_no_hang", 32'(got_timed_out), 0);
        check("to_err", 32'(got_err), 1);
        check("to_rdata", got_rdata, 0);
        check("to_latency", got_lat, TIMEOUT + 3);
        check("to_ren", got_ren_n, 1);
        stub_hi = 1'b0;

        // Reset in the middle of a store: write enable must drop at once, no write lands
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        check("rst_wr_wen_on", 32'(mem_wen), 1);
        reset = 1'b0; #1;
        check("rst_wr_wen_async", 32'(mem_wen), 0);
        check("rst_wr_rsp", 32'(rsp_valid), 0);
        req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        count_rsp(6, seen);
        check("rst_wr_no_rsp", seen, 0);
        mem_lat = 5;
        run_txn(1'b0, 3'b010, 32'h200, 32'h0);

        // Reset while waiting for read data
        mem_lat = 7;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_ren) found = 1;
        end
        check("rst_rd_issue", 32'(found), 1);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0; #1;
        check("rst_rd_ren", 32'(mem_ren), 0);
        check("rst_rd_wen", 32'(mem_wen), 0);
        check("rst_rd_rsp", 32'(rsp_valid), 0);
        check("rst_rd_rdata", rsp_rdata, 0);
        check("rst_rd_err", 32'(rsp_err), 0);
        check("rst_rd_addr", 32'(mem_addr), 0);
        req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        count_rsp(6, seen);
        check("rst_rd_no_rsp", seen, 0);
        run_txn(1'b0, 3'b010, 32'h104, 32'h0);

        // Randomized mix of loads, stores, illegal encodings and out-of-range addresses
        for (int n = 0; n < 80; n++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = ld_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) addr = 32'($urandom_range(1024, 2047));
            else                           addr = 32'($urandom_range(0, 1023));
            mem_lat = $urandom_range(2, 8);
            run_txn(we, f3, addr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
